// File: rtl/midi_rx.sv
// ---------------------------------------------------------------------------
// midi_rx -- MIDI (31250 baud, 8N1, LSB first) serial byte receiver.
//
// A free-running divider produces one oversample tick every OVS_MODULO
// enabled clock cycles (16 ticks per bit). A five-state FSM finds the start
// bit, confirms it at mid-bit, samples each data bit at the middle of its
// bit cell and checks the stop bit. A good frame updates DATA and DISP and
// pulses DV. A bad stop bit pulses FERR, and the receiver then waits for
// the line to go idle again.
//
// Parameters
//   OVS_MODULO  clock cycles per oversample tick (default 100 at 50 MHz)
//   W           width of the tick-divider counter, 2**W >= OVS_MODULO
//
// Ports
//   CLK   in   system clock; every register uses the rising edge
//   CLR   in   synchronous active-high reset; overrides CE
//   CE    in   clock enable; when low all receiver state holds
//   RXD   in   asynchronous serial line, idle high
//   DATA  out  last correctly framed byte
//   DV    out  one-cycle strobe, DATA/DISP updated this cycle
//   FERR  out  one-cycle strobe, framing error and byte discarded
//   DISP  out  held copy of DATA for the 7-segment stage
// ---------------------------------------------------------------------------
module midi_rx #(
  parameter int unsigned OVS_MODULO = 100,
  parameter int unsigned W          = 7
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       DV,
  output logic       FERR,
  output logic [7:0] DISP
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

  localparam logic [W-1:0] DIV_LAST  = W'(OVS_MODULO - 1);
  localparam logic [3:0]   MID_START = 4'd7;   // 8th tick = middle of start bit
  localparam logic [3:0]   BIT_LAST  = 4'd15;  // 16th tick = one full bit later

  // Synchronizer
  logic         rxd_meta_q;
  logic         rxd_s_q;

  // Tick divider
  logic [W-1:0] div_q, div_d;
  logic         tick;

  // Receiver FSM and datapath
  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   shift_q, shift_d;
  logic [7:0]   data_q, data_d;
  logic [7:0]   disp_q, disp_d;
  logic         dv_q, dv_d;
  logic         ferr_q, ferr_d;

  // -------------------------------------------------------------------------
  // Tick divider: free-running, never restarted by the start edge. Because
  // of that the start edge is only seen to within one tick, which the
  // mid-bit sampling absorbs easily.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: give every combinational output a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    div_d = div_q;
    tick  = 1'b0;
    if (CE) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        tick  = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. tick already includes CE, so the FSM and the sample
  // counter only move on enabled tick cycles.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    disp_d  = disp_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          // A falling edge only counts here; edges in other states are ignored.
          if (!rxd_s_q) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end

        ST_START: begin
          if (cnt_q == MID_START) begin
            if (!rxd_s_q) begin
              state_d = ST_DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              // Line went high again before mid-bit: treat it as a glitch.
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            shift_d[bit_q] = rxd_s_q;
            cnt_d          = '0;
            bit_d          = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rxd_s_q) begin
              data_d  = shift_q;
              disp_d  = shift_q;
              dv_d    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        ST_WAIT_IDLE: begin
          // A low stop bit may be a break; wait for the line to go idle.
          if (rxd_s_q) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers. CLR has priority over CE. The two strobes are not held
  // by CE: they fall on the cycle after they rise, so each lasts exactly one
  // clock even when CE is low on that next cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before this clock edge.
    if (CLR) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      div_q      <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      disp_q     <= '0;
      dv_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      if (CE) begin
        rxd_meta_q <= RXD;
        rxd_s_q    <= rxd_meta_q;
        div_q      <= div_d;
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        bit_q      <= bit_d;
        shift_q    <= shift_d;
        data_q     <= data_d;
        disp_q     <= disp_d;
      end
      dv_q   <= dv_d;
      ferr_q <= ferr_d;
    end
  end

  assign DATA = data_q;
  assign DISP = disp_q;
  assign DV   = dv_q;
  assign FERR = ferr_q;

endmodule

// File: tb/tb_midi_rx.sv
// ---------------------------------------------------------------------------
// tb_midi_rx -- bench for midi_rx with OVS_MODULO=4 (one bit = 64 clocks).
// Stimulus pushes the expected strobe (kind, DATA, DISP) into a queue before
// each frame; a separate monitor pops and compares on every DV or FERR.
// ---------------------------------------------------------------------------
module tb_midi_rx;

  localparam int BIT_CLKS = 64;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       CE  = 1'b1;
  logic       RXD = 1'b1;
  logic [7:0] DATA;
  logic       DV;
  logic       FERR;
  logic [7:0] DISP;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic [7:0] disp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_en  = 1'b0;
  logic ce_gate = 1'b0;

  midi_rx #(.OVS_MODULO(4), .W(2)) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .CE   (CE),
    .RXD  (RXD),
    .DATA (DATA),
    .DV   (DV),
    .FERR (FERR),
    .DISP (DISP)
  );

  always #5 CLK = ~CLK;

  // 50% CE toggling when gating is enabled, otherwise CE stays high.
  always @(negedge CLK) begin
    CE = ce_gate ? ~CE : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are registered, so sampling on the falling edge is safe.
  always @(negedge CLK) begin
    if (mon_en && (DV === 1'b1 || FERR === 1'b1)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: dv=%b ferr=%b data=0x%0h (t=%0t)", DV, FERR, DATA, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_ferr", 32'(FERR), 32'(e.ferr));
        check("strobe_dv",   32'(DV),   32'(!e.ferr));
        check("strobe_data", 32'(DATA), 32'(e.data));
        check("strobe_disp", 32'(DISP), 32'(e.disp));
      end
    end
  end

  // Drives one frame; leaves RXD at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_clks);
    RXD = 1'b0;
    repeat (bit_clks) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (bit_clks) @(negedge CLK);
    end
    RXD = stop_bit;
    repeat (bit_clks) @(negedge CLK);
  endtask

  task automatic push_exp(input logic ferr, input logic [7:0] d, input logic [7:0] p);
    exp_t e;
    e.ferr = ferr;
    e.data = d;
    e.disp = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (100) @(negedge CLK);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: 3 cycles with RXD high.
    RXD = 1'b1;
    CLR = 1'b1;
    repeat (3) @(negedge CLK);
    check("reset_data", 32'(DATA), 32'h00);
    check("reset_disp", 32'(DISP), 32'h00);
    check("reset_dv",   32'(DV),   32'h0);
    check("reset_ferr", 32'(FERR), 32'h0);
    CLR = 1'b0;
    mon_en = 1'b1;
    repeat (100) @(negedge CLK);

    // Single good frame.
    push_exp(1'b0, 8'hA5, 8'hA5);
    send_frame(8'hA5, 1'b1, BIT_CLKS);
    wait_drain(1000);

    // Glitch: 16 clocks (4 ticks) low, well short of the mid-bit check.
    RXD = 1'b0;
    repeat (16) @(negedge CLK);
    RXD = 1'b1;
    repeat (200) @(negedge CLK);
    push_exp(1'b0, 8'h3C, 8'h3C);
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    wait_drain(1000);

    // Framing error: DATA and DISP keep 0x3C.
    push_exp(1'b1, 8'h3C, 8'h3C);
    send_frame(8'h5A, 1'b0, BIT_CLKS);
    repeat (2 * BIT_CLKS) @(negedge CLK);
    RXD = 1'b1;
    repeat (200) @(negedge CLK);
    wait_drain(1000);
    push_exp(1'b0, 8'h81, 8'h81);
    send_frame(8'h81, 1'b1, BIT_CLKS);
    wait_drain(1000);

    // Back-to-back stream with CE at 50% and the bit period doubled.
    ce_gate = 1'b1;
    push_exp(1'b0, 8'h90, 8'h90);
    push_exp(1'b0, 8'h3C, 8'h3C);
    push_exp(1'b0, 8'h7F, 8'h7F);
    send_frame(8'h90, 1'b1, 2 * BIT_CLKS);
    send_frame(8'h3C, 1'b1, 2 * BIT_CLKS);
    send_frame(8'h7F, 1'b1, 2 * BIT_CLKS);
    wait_drain(4000);
    ce_gate = 1'b0;
    repeat (100) @(negedge CLK);

    // Reset in the middle of bit 4 of 0xFF.
    RXD = 1'b0;
    repeat (BIT_CLKS) @(negedge CLK);
    RXD = 1'b1;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge CLK);
    CLR = 1'b1;
    repeat (3) @(negedge CLK);
    check("midreset_data", 32'(DATA), 32'h00);
    check("midreset_disp", 32'(DISP), 32'h00);
    CLR = 1'b0;
    repeat (6 * BIT_CLKS) @(negedge CLK);
    push_exp(1'b0, 8'h12, 8'h12);
    send_frame(8'h12, 1'b1, BIT_CLKS);
    wait_drain(1000);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/midi_rx.md
MIDI_RX -- requirements
Module: midi_rx

Interface
REQ-001 Parameter OVS_MODULO, default 100; meaning: CLK cycles per oversample tick (16 ticks per bit; 50 MHz / (31250 x 16) = 100).
REQ-002 Parameter W, default 7; meaning: width of the tick-divider counter; SHALL satisfy 2^W >= OVS_MODULO.
REQ-003 CLK  input  1  system clock; all logic on the rising edge.
REQ-004 CLR  input  1  reset; synchronous, active-high.
REQ-005 CE  input  1  clock enable; when low, every register holds its value.
REQ-006 RXD  input  1  asynchronous serial MIDI line; idle high; 8N1, LSB first.
REQ-007 DATA  output  8  last correctly framed byte.
REQ-008 DV  output  1  one-cycle strobe: DATA updated this cycle.
REQ-009 FERR  output  1  one-cycle strobe: framing error, byte discarded.
REQ-010 DISP  output  8  held copy of DATA for the 7-segment stage BIN_IN; changes only when DV is high.

Function
REQ-011 RXD SHALL pass through a 2-flop synchronizer (rxd_s) before any use; the synchronizer flops reset to 1.
REQ-012 The tick divider SHALL count 0..OVS_MODULO-1 while CE=1, wrap to 0, and assert tick for one cycle when count = OVS_MODULO-1; it free-runs and is not restarted by the start edge.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_IDLE; all transitions and sample-counter updates occur only on CE=1 and tick=1.
REQ-014 IDLE: if rxd_s=0, go to START with sample count 0; otherwise stay in IDLE.
REQ-015 START: increment the sample count; at the 8th tick (count 7), rxd_s=0 goes to DATA with count=0 and bit index=0; rxd_s=1 is a glitch and goes to IDLE with no strobe.
REQ-016 DATA: on every 16th tick (count 15), shift rxd_s into bit position [bit index] (LSB first), reset count to 0 and increment the bit index; after bit 7, go to STOP.
REQ-017 STOP: on the 16th tick, rxd_s=1 loads DATA and DISP with the shifted byte, pulses DV and goes to IDLE.
REQ-018 STOP: on the 16th tick, rxd_s=0 pulses FERR, leaves DATA and DISP unchanged, and goes to WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL return to IDLE on the first tick where rxd_s=1.
REQ-020 DV and FERR SHALL each be high for exactly one CLK cycle per frame, SHALL be mutually exclusive, and SHALL never be high in the same cycle.
REQ-021 DV SHALL rise one cycle after the tick on which the stop bit is sampled; DATA and DISP become valid in that same cycle.
REQ-022 A falling edge on RXD SHALL be accepted in IDLE only; edges in other states are ignored.
REQ-023 Back-to-back frames, where the next start bit directly follows the stop bit, SHALL all be received without loss.
REQ-024 CE=0 mid-frame SHALL freeze the divider, the FSM, and the shift and sample registers; reception resumes exactly where it stopped when CE returns to 1.

Reset
REQ-025 CLR=1 SHALL take priority over CE and SHALL set: FSM state IDLE, divider 0, sample count 0, bit index 0, shift register 0x00, DATA 0x00, DISP 0x00, DV 0, FERR 0, synchronizer flops 1.
REQ-026 CLR asserted mid-frame SHALL abort the frame with no DV and no FERR; the next start bit after CLR is released SHALL be received normally.

Verification (OVS_MODULO=4, so 1 bit = 64 CLK cycles)
REQ-027 Reset: apply CLR for 3 cycles with RXD=1 -> DATA=0x00, DISP=0x00, DV=0, FERR=0, FSM in IDLE.
REQ-028 Single frame: send 0xA5 with a valid stop bit -> exactly one DV pulse; DATA=0xA5 and DISP=0xA5; FERR never high.
REQ-029 Glitch: drive RXD low for 16 cycles (4 ticks), then high -> no DV, no FERR; a following 0x3C frame is received as 0x3C.
REQ-030 Framing error: send 0x5A with stop bit=0, hold RXD low for 2 more bit times, then high -> one FERR pulse, no DV, DISP keeps its previous value; the next 0x81 frame gives DV and DATA=0x81.
REQ-031 Stream with CE gating: send 0x90, 0x3C, 0x7F back-to-back while toggling CE with a 50% duty cycle and the bit period doubled to match -> three DV pulses with DATA = 0x90, 0x3C, 0x7F in order.
REQ-032 Reset mid-frame: assert CLR during bit 4 of 0xFF, release it, then send 0x12 -> no strobe for the aborted frame; DV with DATA=0x12.
